// File: rtl/mont_final_sub.sv
// Final conditional subtraction of a Montgomery step: result = (T >= M) ? T - M : T.
// The 1028-bit subtraction runs one limb per cycle with a registered borrow between limbs.
module mont_final_sub #(
   parameter int LIMB_W = 128,
   parameter int NLIMB  = 9
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [1027:0] in_t,
   input  logic [1026:0] in_m,
   output logic          busy,
   output logic          done,
   output logic [1026:0] result
);

   localparam int PW = NLIMB * LIMB_W;
   localparam int CW = (NLIMB > 1) ? $clog2(NLIMB) : 1;

   typedef enum logic [1:0] {IDLE, SUB, SEL} state_t;

   state_t          state;
   logic [PW-1:0]   t_sr;
   logic [PW-1:0]   m_sr;
   logic [PW-1:0]   d_sr;
   logic [1026:0]   t_copy;
   logic            borrow;
   logic [CW-1:0]   cnt;
   logic [LIMB_W:0] diff;

   // Top bit of the (LIMB_W+1)-bit difference is the borrow out of this limb.
   assign diff = {1'b0, t_sr[LIMB_W-1:0]} - {1'b0, m_sr[LIMB_W-1:0]}
               - {{LIMB_W{1'b0}}, borrow};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         t_sr   <= '0;
         m_sr   <= '0;
         d_sr   <= '0;
         t_copy <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  t_sr   <= PW'(in_t);
                  m_sr   <= PW'(in_m);
                  t_copy <= in_t[1026:0];
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= SUB;
               end
            end
            SUB: begin
               d_sr   <= {diff[LIMB_W-1:0], d_sr[PW-1:LIMB_W]};
               t_sr   <= t_sr >> LIMB_W;
               m_sr   <= m_sr >> LIMB_W;
               borrow <= diff[LIMB_W];
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(NLIMB - 1)) state <= SEL;
            end
            SEL: begin
               // A final borrow means T < M, so T itself is already reduced.
               result <= borrow ? t_copy : d_sr[1026:0];
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
